present_host_master: RTL and testbench

- Host-side initiator for the 4-bit nibble register bus of the PRESENT tile (the "other end" of that bus).
- Takes a 64-bit plaintext and an 80-bit key, then drives the tile's Addr/Data pins to load the key and plaintext and to start the engine.
- Polls the tile's Ready status bit, reads back the 64-bit ciphertext and presents it with a done pulse.
- Used in the FPGA companion design and as the bus-functional driver in system benches.

---
 rtl/present_host_master.sv | 160 ++++++++++++++++
 tb/tb_present_host_master.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/present_host_master.sv
// Host-side initiator for the PRESENT tile nibble register bus.
// Loads key and plaintext, starts the engine, polls Ready and reads back the ciphertext.
module present_host_master #(
    parameter int READY_TIMEOUT = 4095
) (
    input  logic        Clk_ik,
    input  logic        Reset_ir,
    input  logic        Start_i,
    input  logic        KeyLoad_i,
    input  logic [63:0] PlainText_ib,
    input  logic [79:0] Key_ib,
    output logic [63:0] CipherText_ob,
    output logic        Busy_o,
    output logic        Done_o,
    output logic        Error_o,
    output logic [1:0]  Addr_ob,
    output logic [3:0]  Data_ob,
    input  logic [7:0]  Data_ib
);
    typedef enum logic [2:0] {IDLE, WR_KEY, WR_PT, START, POLL, RD_CT, DONE, ERR} state_t;

    localparam logic [11:0] TIMEOUT_LAST = 12'(READY_TIMEOUT - 1);

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_phase, w_phase_nxt;
    logic [3:0]  r_idx, w_idx_nxt;
    logic [11:0] r_poll, w_poll_nxt;
    logic        r_seen_low, w_seen_low_nxt;
    logic [63:0] r_pt;
    logic [79:0] r_key;
    logic [3:0]  w_last_idx;
    logic [7:0]  w_slot_addr, w_slot_byte;
    logic        w_rd;
    logic [1:0]  w_addr_nxt;
    logic [3:0]  w_data_nxt;

    assign w_last_idx = (r_state == WR_KEY) ? 4'd9 : 4'd7;

    always_comb begin
        // NOTE: every combinational output is defaulted first so no path can infer a latch.
        w_state_nxt    = r_state;
        w_phase_nxt    = r_phase;
        w_idx_nxt      = r_idx;
        w_poll_nxt     = r_poll;
        w_seen_low_nxt = r_seen_low;
        case (r_state)
            IDLE: begin
                if (Start_i) begin
                    w_state_nxt = KeyLoad_i ? WR_KEY : WR_PT;
                    w_phase_nxt = 3'd0;
                    w_idx_nxt   = 4'd0;
                end
            end
            WR_KEY, WR_PT, RD_CT: begin
                w_phase_nxt = r_phase + 3'd1;
                if (r_phase == 3'd7) begin
                    w_idx_nxt = r_idx + 4'd1;
                    if (r_idx == w_last_idx) begin
                        w_idx_nxt   = 4'd0;
                        w_state_nxt = (r_state == WR_KEY) ? WR_PT :
                                      (r_state == WR_PT)  ? START : DONE;
                    end
                end
            end
            START: begin
                w_state_nxt    = POLL;
                w_poll_nxt     = 12'd0;
                w_seen_low_nxt = 1'b0;
            end
            POLL: begin
                w_poll_nxt = r_poll + 12'd1;
                // The first three poll cycles may still show Ready from the previous run.
                if (r_poll >= 12'd3) begin
                    if (Data_ib[0] && r_seen_low) w_state_nxt = RD_CT;
                    else if (!Data_ib[0])         w_seen_low_nxt = 1'b1;
                end
                if (w_state_nxt == POLL && r_poll == TIMEOUT_LAST) w_state_nxt = ERR;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Bus values are derived from the next slot position so the pins themselves are registered.
    assign w_rd        = (w_state_nxt == RD_CT);
    assign w_slot_addr = {(w_state_nxt == WR_KEY) ? 4'h1 : 4'h0, w_idx_nxt};
    assign w_slot_byte = (w_state_nxt == WR_KEY) ? r_key[{w_idx_nxt, 3'b000} +: 8]
                                                 : r_pt[{w_idx_nxt[2:0], 3'b000} +: 8];

    always_comb begin
        w_addr_nxt = 2'b00;
        w_data_nxt = 4'h0;
        case (w_state_nxt)
            WR_KEY, WR_PT, RD_CT: begin
                case (w_phase_nxt)
                    3'd0: begin w_addr_nxt = 2'b10; w_data_nxt = w_slot_addr[3:0]; end
                    3'd1: begin w_addr_nxt = 2'b11; w_data_nxt = w_slot_addr[7:4]; end
                    3'd2: begin w_addr_nxt = 2'b01; w_data_nxt = 4'b0001; end
                    3'd4: begin
                        w_addr_nxt = w_rd ? 2'b01   : 2'b10;
                        w_data_nxt = w_rd ? 4'b0010 : w_slot_byte[3:0];
                    end
                    3'd5: begin
                        w_addr_nxt = w_rd ? 2'b00 : 2'b11;
                        w_data_nxt = w_rd ? 4'h0  : w_slot_byte[7:4];
                    end
                    3'd6: begin
                        w_addr_nxt = w_rd ? 2'b10 : 2'b01;
                        w_data_nxt = w_rd ? w_slot_addr[3:0] : 4'b0100;
                    end
                    3'd7: begin
                        w_addr_nxt = w_rd ? 2'b10 : 2'b00;
                        w_data_nxt = w_rd ? w_slot_addr[3:0] : 4'h0;
                    end
                    default: ;
                endcase
            end
            START:   begin w_addr_nxt = 2'b01; w_data_nxt = 4'b1000; end
            default: ;
        endcase
    end

    always_ff @(posedge Clk_ik or posedge Reset_ir) begin
        if (Reset_ir) begin
            r_state       <= IDLE;
            r_phase       <= 3'd0;
            r_idx         <= 4'd0;
            r_poll        <= 12'd0;
            r_seen_low    <= 1'b0;
            Addr_ob       <= 2'b00;
            Data_ob       <= 4'h0;
            CipherText_ob <= 64'h0;
            Busy_o        <= 1'b0;
            Done_o        <= 1'b0;
            Error_o       <= 1'b0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
            r_state    <= w_state_nxt;
            r_phase    <= w_phase_nxt;
            r_idx      <= w_idx_nxt;
            r_poll     <= w_poll_nxt;
            r_seen_low <= w_seen_low_nxt;
            Addr_ob    <= w_addr_nxt;
            Data_ob    <= w_data_nxt;
            Busy_o     <= w_state_nxt inside {WR_KEY, WR_PT, START, POLL, RD_CT};
            Done_o     <= (w_state_nxt == DONE);
            if (r_state == IDLE && Start_i) Error_o <= 1'b0;
            else if (w_state_nxt == ERR)    Error_o <= 1'b1;
            if (r_state == RD_CT && r_phase == 3'd7)
                CipherText_ob[{r_idx[2:0], 3'b000} +: 8] <= Data_ib;
        end
    end

    // NOTE: payload registers carry no reset; they are always loaded before being driven onto the bus.
    always_ff @(posedge Clk_ik) begin
        if (r_state == IDLE && Start_i) begin
            r_pt  <= PlainText_ib;
            r_key <= Key_ib;
        end
    end
endmodule

// File: tb/tb_present_host_master.sv
// Self-checking bench: behavioural PRESENT tile slave plus a ciphertext scoreboard.
module tb_present_host_master;
    logic        Clk_ik = 1'b0;
    logic        Reset_ir;
    logic        Start_i;
    logic        KeyLoad_i;
    logic [63:0] PlainText_ib;
    logic [79:0] Key_ib;
    logic [63:0] CipherText_ob;
    logic        Busy_o, Done_o, Error_o;
    logic [1:0]  Addr_ob;
    logic [3:0]  Data_ob;
    logic [7:0]  Data_ib;

    int n_assert = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];

    always #5 Clk_ik = ~Clk_ik;

    present_host_master #(.READY_TIMEOUT(16)) dut (
        .Clk_ik(Clk_ik), .Reset_ir(Reset_ir), .Start_i(Start_i), .KeyLoad_i(KeyLoad_i),
        .PlainText_ib(PlainText_ib), .Key_ib(Key_ib), .CipherText_ob(CipherText_ob),
        .Busy_o(Busy_o), .Done_o(Done_o), .Error_o(Error_o),
        .Addr_ob(Addr_ob), .Data_ob(Data_ob), .Data_ib(Data_ib)
    );

    // ---------------- reference cipher ----------------
    function automatic logic [3:0] sbox4(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
            4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
            4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
            4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
        endcase
    endfunction

    function automatic logic [63:0] present80(input logic [63:0] pt, input logic [79:0] key);
        logic [63:0] s, t;
        logic [79:0] k;
        s = pt;
        k = key;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ k[79:16];
            for (int i = 0; i < 16; i++) s[4*i +: 4] = sbox4(s[4*i +: 4]);
            t = '0;
            for (int i = 0; i < 63; i++) t[(i * 16) % 63] = s[i];
            t[63] = s[63];
            s = t;
            k = {k[18:0], k[79:19]};
            k[79:76] = sbox4(k[79:76]);
            k[19:15] = k[19:15] ^ 5'(r);
        end
        return s ^ k[79:16];
    endfunction

    // ---------------- tile slave model ----------------
    logic [1:0]  t_a = 2'b00;
    logic [3:0]  t_d = 4'h0;
    logic [7:0]  t_din, t_adr, t_out;
    logic [7:0]  t_key [10];
    logic [7:0]  t_pt  [8];
    logic [63:0] t_ct, t_last_pt;
    logic        t_ready = 1'b1;
    int          t_busy = 0;
    int          key_latches = 0;
    bit          stuck_ready = 1'b0;

    function automatic logic [63:0] t_pt_word();
        logic [63:0] w;
        for (int n = 0; n < 8; n++) w[8*n +: 8] = t_pt[n];
        return w;
    endfunction

    function automatic logic [79:0] t_key_word();
        logic [79:0] w;
        for (int n = 0; n < 10; n++) w[8*n +: 8] = t_key[n];
        return w;
    endfunction

    assign Data_ib = Addr_ob[1] ? t_out : (stuck_ready ? 8'h01 : {7'b0, t_ready});

    // The tile registers the pins and acts on them one edge later.
    always @(posedge Clk_ik) begin
        t_a <= Addr_ob;
        t_d <= Data_ob;
        if (t_busy > 0) begin
            t_busy <= t_busy - 1;
            if (t_busy == 1) t_ready <= 1'b1;
        end
        case (t_a)
            2'b10: t_din[3:0] <= t_d;
            2'b11: t_din[7:4] <= t_d;
            2'b01: begin
                if (t_d[0]) begin
                    t_adr <= t_din;
                    if (t_din[7:4] == 4'h1) key_latches <= key_latches + 1;
                end
                if (t_d[2]) begin
                    if (t_adr[7:4] == 4'h1 && t_adr[3:0] < 4'd10) t_key[t_adr[3:0]] <= t_din;
                    else if (t_adr < 8'd8)                       t_pt[t_adr[2:0]]  <= t_din;
                end
                if (t_d[1]) t_out <= t_ct[{t_adr[2:0], 3'b000} +: 8];
                if (t_d[3]) begin
                    t_ct      <= present80(t_pt_word(), t_key_word());
                    t_last_pt <= t_pt_word();
                    t_ready   <= 1'b0;
                    t_busy    <= 8;
                end
            end
            default: ;
        endcase
    end

    // ---------------- monitors ----------------
    int done_count = 0;
    int cmd_viol   = 0;
    logic [1:0] prev_a = 2'b00;
    always @(negedge Clk_ik) begin
        if (Done_o) done_count <= done_count + 1;
        if (prev_a == 2'b01 && (Addr_ob != 2'b00 || Data_ob != 4'h0)) cmd_viol <= cmd_viol + 1;
        prev_a <= Addr_ob;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge Clk_ik);
        #1;
    endtask

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic kl, input logic [63:0] pt, input logic [79:0] key);
        PlainText_ib = pt;
        Key_ib       = key;
        KeyLoad_i    = kl;
        Start_i      = 1'b1;
        tick();
        Start_i      = 1'b0;
    endtask

    task automatic check_first_slot(input string tag, input logic [7:0] a, input logic [7:0] b);
        logic [5:0] q[$];
        logic [5:0] e;
        q.push_back({2'b10, a[3:0]}); q.push_back({2'b11, a[7:4]});
        q.push_back({2'b01, 4'h1});   q.push_back({2'b00, 4'h0});
        q.push_back({2'b10, b[3:0]}); q.push_back({2'b11, b[7:4]});
        q.push_back({2'b01, 4'h4});   q.push_back({2'b00, 4'h0});
        for (int s = 0; s < 8; s++) begin
            e = q.pop_front();
            check($sformatf("%s slot s%0d", tag, s), {74'h0, Addr_ob, Data_ob}, {74'h0, e});
            tick();
        end
    endtask

    task automatic finish_run(input string tag);
        int c;
        logic [63:0] e;
        c = 0;
        while (!Done_o && !Error_o && c < 600) begin
            tick();
            c++;
        end
        check({tag, " done"}, {79'h0, Done_o}, 80'h1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'h0;
        check({tag, " ciphertext"}, {16'h0, CipherText_ob}, {16'h0, e});
        check({tag, " busy low at done"}, {79'h0, Busy_o}, 80'h0);
        check({tag, " no error"}, {79'h0, Error_o}, 80'h0);
        tick();
        check({tag, " done one cycle"}, {79'h0, Done_o}, 80'h0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [63:0] pt_a, pt_b;
        logic [79:0] key_a;
        int kl_before, dc_before, c_start, c_err;

        Reset_ir = 1'b1; Start_i = 1'b0; KeyLoad_i = 1'b0;
        PlainText_ib = '0; Key_ib = '0;
        tick(); tick();
        check("reset addr",   {78'h0, Addr_ob}, 80'h0);
        check("reset data",   {76'h0, Data_ob}, 80'h0);
        check("reset ct",     {16'h0, CipherText_ob}, 80'h0);
        check("reset flags",  {77'h0, Busy_o, Done_o, Error_o}, 80'h0);
        Reset_ir = 1'b0;
        tick();

        // Known-answer run with key load.
        exp_q.push_back(64'h5579C1387B228445);
        do_start(1'b1, 64'h0, 80'h0);
        check("run1 busy", {79'h0, Busy_o}, 80'h1);
        check_first_slot("run1", 8'h10, 8'h00);
        finish_run("run1");

        // Key reuse: a different key on the pins must never reach the tile.
        kl_before = key_latches;
        exp_q.push_back(64'hA112FFC72F68417B);
        do_start(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 80'hDEAD_BEEF_0123_4567_89AB);
        check_first_slot("reuse", 8'h00, 8'hFF);
        finish_run("reuse");
        check("reuse no key access", 80'(key_latches - kl_before), 80'h0);

        // Random run with key load, first slot carries key byte 0.
        pt_a  = {$urandom, $urandom};
        key_a = {16'($urandom), $urandom, $urandom};
        exp_q.push_back(present80(pt_a, key_a));
        do_start(1'b1, pt_a, key_a);
        check_first_slot("rand", 8'h10, key_a[7:0]);
        finish_run("rand");

        // Start pulses while busy are ignored.
        pt_a  = {$urandom, $urandom};
        pt_b  = ~pt_a;
        key_a = {16'($urandom), $urandom, $urandom};
        exp_q.push_back(present80(pt_a, key_a));
        dc_before = done_count;
        do_start(1'b1, pt_a, key_a);
        for (int c = 2; c <= 100; c++) begin
            if (c == 5 || c == 100) begin
                PlainText_ib = pt_b; Key_ib = ~key_a; KeyLoad_i = 1'b0; Start_i = 1'b1;
            end
            tick();
            Start_i = 1'b0;
        end
        finish_run("busyrej");
        check("busyrej tile plaintext", {16'h0, t_last_pt}, {16'h0, pt_a});
        repeat (300) tick();
        check("busyrej single done", 80'(done_count - dc_before), 80'h1);
        check("busyrej idle after", {79'h0, Busy_o}, 80'h0);

        // Ready stuck high: timeout at poll cycle 16.
        stuck_ready = 1'b1;
        dc_before = done_count;
        do_start(1'b0, 64'h0123_4567_89AB_CDEF, 80'h0);
        c_start = -1;
        c_err   = -1;
        for (int c = 1; c <= 300; c++) begin
            if (Addr_ob == 2'b01 && Data_ob == 4'b1000) c_start = c;
            if (Error_o) begin
                c_err = c;
                break;
            end
            tick();
        end
        check("timeout latency", 80'(c_err - c_start), 80'd17);
        check("timeout busy low", {79'h0, Busy_o}, 80'h0);
        repeat (5) tick();
        check("timeout error sticky", {79'h0, Error_o}, 80'h1);
        check("timeout no done", 80'(done_count - dc_before), 80'h0);
        stuck_ready = 1'b0;
        pt_a = {$urandom, $urandom};
        exp_q.push_back(present80(pt_a, key_a));
        do_start(1'b0, pt_a, 80'h0);
        check("restart clears error", {79'h0, Error_o}, 80'h0);
        finish_run("after_timeout");

        // Asynchronous reset in the middle of the plaintext writes.
        do_start(1'b1, {$urandom, $urandom}, {16'($urandom), $urandom, $urandom});
        repeat (89) tick();
        check("pre-reset busy", {79'h0, Busy_o}, 80'h1);
        #2 Reset_ir = 1'b1;
        #1;
        check("async reset addr", {78'h0, Addr_ob}, 80'h0);
        check("async reset busy", {79'h0, Busy_o}, 80'h0);
        check("async reset ct",   {16'h0, CipherText_ob}, 80'h0);
        tick(); tick();
        Reset_ir = 1'b0;
        tick();
        pt_a  = {$urandom, $urandom};
        key_a = {16'($urandom), $urandom, $urandom};
        exp_q.push_back(present80(pt_a, key_a));
        do_start(1'b1, pt_a, key_a);
        check_first_slot("post_reset", 8'h10, key_a[7:0]);
        finish_run("post_reset");

        check("command followed by idle", 80'(cmd_viol), 80'h0);
        check("scoreboard drained", 80'(exp_q.size()), 80'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
